// File: rtl/mem_pkg.sv
// Shared opcodes, in-flight metadata and load lane extraction
// for the memory stage.
package mem_pkg;

    localparam logic [6:0] OP_LDB = 7'h10;
    localparam logic [6:0] OP_LDW = 7'h11;
    localparam logic [6:0] OP_STB = 7'h12;
    localparam logic [6:0] OP_STW = 7'h13;

    typedef struct packed {
        logic       wb;
        logic [4:0] dst;
        logic [1:0] lane;
        logic       byte_op;
        logic       fault;
    } mem_meta_t;

    function automatic logic [31:0] lane_sel(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic        byte_op
    );
        logic [7:0] b;
        unique case (lane)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        return byte_op ? {{24{b[7]}}, b} : w;
    endfunction

endpackage

// File: rtl/mem_bram.sv
// Word-organised RAM with four byte-lane write enables and a
// registered read port.
module mem_bram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: byte/word loads and stores with
// one or two cycle load latency and misalignment faults.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              stall,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [4:0]        dst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [6:0]        memOP,
    output logic              ready,
    output logic              WB,
    output logic [4:0]        dstout,
    output logic [DATA_W-1:0] data_out,
    output logic              fault
);

    localparam int WA = ADDR_W - 2;

    logic        acc;
    logic        ld;
    logic        st;
    logic        byte_op;
    logic        mis;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] d1;
    mem_meta_t   meta_in;
    mem_meta_t   s1;
    mem_meta_t   so;
    logic [31:0] dout;

    assign ready = !stall;
    assign acc   = enable && !stall;

    always_comb begin
        ld      = 1'b0;
        st      = 1'b0;
        byte_op = 1'b0;
        unique case (1'b1)
            (memOP == OP_LDB): begin ld = 1'b1; byte_op = 1'b1; end
            (memOP == OP_LDW): ld = 1'b1;
            (memOP == OP_STB): begin st = 1'b1; byte_op = 1'b1; end
            (memOP == OP_STW): st = 1'b1;
            default: ;
        endcase
    end

    assign mis = (ld || st) && !byte_op && (MemAddr[1:0] != 2'b00);

    always_comb begin
        we = 4'b0000;
        if (acc && st && !mis)
            we = byte_op ? (4'b0001 << MemAddr[1:0]) : 4'b1111;
    end

    assign wdata = byte_op ? {4{data_in[7:0]}} : data_in;

    always_comb begin
        meta_in         = '0;
        meta_in.wb      = enable && ld && !mis;
        meta_in.dst     = meta_in.wb ? dst : 5'd0;
        meta_in.lane    = MemAddr[1:0];
        meta_in.byte_op = byte_op;
        meta_in.fault   = enable && mis;
    end

    mem_bram #(.AW(WA)) u_bram (
        .clk   (clk),
        .rd_en (!stall),
        .addr  (MemAddr[ADDR_W-1:2]),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      s1 <= '0;
        else if (!stall) s1 <= meta_in;
    end

    // Data is gated by the stage's WB so reset zeroes it at once
    assign d1 = s1.wb ? lane_sel(rdata, s1.lane, s1.byte_op) : 32'd0;

    generate
        if (RD_LAT == 2) begin : g_lat2
            mem_meta_t   s2;
            logic [31:0] d2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2 <= '0;
                    d2 <= '0;
                end else if (!stall) begin
                    s2 <= s1;
                    d2 <= d1;
                end
            end
            assign so   = s2;
            assign dout = d2;
        end else begin : g_lat1
            assign so   = s1;
            assign dout = d1;
        end
    endgenerate

    assign WB       = so.wb;
    assign dstout   = so.dst;
    assign data_out = dout;
    assign fault    = so.fault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench: two mem_stage copies (RD_LAT 1 and 2) on
// shared stimulus, outputs checked with immediate assertions.
module tb_mem_stage;

    localparam logic [6:0] LDB = 7'h10;
    localparam logic [6:0] LDW = 7'h11;
    localparam logic [6:0] STB = 7'h12;
    localparam logic [6:0] STW = 7'h13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic [9:0]  MemAddr = '0;
    logic [4:0]  dst = '0;
    logic [31:0] data_in = '0;
    logic [6:0]  memOP = '0;

    logic        rdy1, wb1, fl1, rdy2, wb2, fl2;
    logic [4:0]  dso1, dso2;
    logic [31:0] do1, do2;

    int n_chk = 0;
    int n_fail = 0;

    // expected {WB, dstout, data_out, fault} per copy
    logic [38:0] q1 = '0;
    logic [38:0] q2 = '0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall),
        .MemAddr(MemAddr), .dst(dst), .data_in(data_in),
        .memOP(memOP), .ready(rdy1), .WB(wb1), .dstout(dso1),
        .data_out(do1), .fault(fl1)
    );

    mem_stage #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall),
        .MemAddr(MemAddr), .dst(dst), .data_in(data_in),
        .memOP(memOP), .ready(rdy2), .WB(wb2), .dstout(dso2),
        .data_out(do2), .fault(fl2)
    );

    task automatic chk(input string tag, input logic [38:0] got,
                       input logic [38:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, "/lat1"}, {wb1, dso1, do1, fl1}, q1);
        chk({tag, "/lat2"}, {wb2, dso2, do2, fl2}, q2);
    endtask

    // Drive one request for a cycle; expected fields describe
    // what this request produces when it emerges.
    task automatic step(
        input string       tag,
        input logic        en,
        input logic        st,
        input logic [6:0]  op,
        input logic [9:0]  a,
        input logic [4:0]  d,
        input logic [31:0] din,
        input logic        ewb,
        input logic [4:0]  edst,
        input logic [31:0] edat,
        input logic        efl
    );
        @(negedge clk);
        enable  = en;
        stall   = st;
        memOP   = op;
        MemAddr = a;
        dst     = d;
        data_in = din;
        #1;
        chk({tag, "/ready"}, {37'd0, rdy1, rdy2}, {37'd0, !st, !st});
        @(posedge clk);
        #1;
        if (!st) begin
            q2 = q1;
            q1 = en ? {ewb, edst, edat, efl} : 39'd0;
        end
        check_out(tag);
    endtask

    initial begin
        #1;
        check_out("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step("stw4",   1, 0, STW, 10'h004, 5'd1, 32'hDEADBEEF, 0, 0, 0, 0);
        step("ldw4",   1, 0, LDW, 10'h004, 5'd5, 0, 1, 5, 32'hDEADBEEF, 0);
        step("stb6",   1, 0, STB, 10'h006, 5'd2, 32'h00000080, 0, 0, 0, 0);
        step("ldw4b",  1, 0, LDW, 10'h004, 5'd6, 0, 1, 6, 32'hDE80BEEF, 0);
        step("ldb6",   1, 0, LDB, 10'h006, 5'd7, 0, 1, 7, 32'hFFFFFF80, 0);
        step("ldb7",   1, 0, LDB, 10'h007, 5'd8, 0, 1, 8, 32'hFFFFFFDE, 0);
        step("stb5",   1, 0, STB, 10'h005, 5'd2, 32'hFFFFFF12, 0, 0, 0, 0);
        step("ldb5",   1, 0, LDB, 10'h005, 5'd9, 0, 1, 9, 32'h00000012, 0);
        step("ldb4",   1, 0, LDB, 10'h004, 5'd3, 0, 1, 3, 32'hFFFFFFEF, 0);
        step("ldw5",   1, 0, LDW, 10'h005, 5'd3, 0, 0, 0, 0, 1);
        step("stw7",   1, 0, STW, 10'h007, 5'd3, 32'h12345678, 0, 0, 0, 1);
        step("ldw4c",  1, 0, LDW, 10'h004, 5'd4, 0, 1, 4, 32'hDE8012EF, 0);
        step("nop",    1, 0, 7'h00, 10'h004, 5'd9, 0, 0, 0, 0, 0);
        step("bubble", 0, 0, LDW, 10'h004, 5'd9, 0, 0, 0, 0, 0);

        step("stwtop", 1, 0, STW, 10'h3FC, 5'd1, 32'hA5A55A5A, 0, 0, 0, 0);
        step("ldwtop", 1, 0, LDW, 10'h3FC, 5'd31, 0, 1, 31, 32'hA5A55A5A, 0);
        step("b2b_a",  1, 0, LDW, 10'h004, 5'd2, 0, 1, 2, 32'hDE8012EF, 0);
        step("b2b_b",  1, 0, LDB, 10'h3FF, 5'd3, 0, 1, 3, 32'hFFFFFFA5, 0);
        step("b2b_c",  1, 0, LDB, 10'h3FC, 5'd4, 0, 1, 4, 32'h0000005A, 0);

        step("stl_ld", 1, 0, LDW, 10'h004, 5'd10, 0, 1, 10, 32'hDE8012EF, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, STW, 10'h004, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
        step("release", 0, 0, 7'h00, 10'h000, 5'd0, 0, 0, 0, 0, 0);
        step("nodup",   0, 0, 7'h00, 10'h000, 5'd0, 0, 0, 0, 0, 0);
        step("nowrite", 1, 0, LDW, 10'h004, 5'd11, 0, 1, 11, 32'hDE8012EF, 0);

        step("rst_ld", 1, 0, LDW, 10'h3FC, 5'd12, 0, 1, 12, 32'hA5A55A5A, 0);
        #2;
        rst_n = 1'b0;
        #1;
        q1 = '0;
        q2 = '0;
        check_out("async_rst");
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("first",  1, 0, LDW, 10'h004, 5'd13, 0, 1, 13, 32'hDE8012EF, 0);
        step("flushd", 0, 0, 7'h00, 10'h000, 5'd0, 0, 0, 0, 0, 0);
        step("memkept", 1, 0, LDW, 10'h3FC, 5'd14, 0, 1, 14, 32'hA5A55A5A, 0);
        step("drain",  0, 0, 7'h00, 10'h000, 5'd0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
